// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, R-type functs,
// ALU operations, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam int unsigned AluOpW = 3;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpXori = 6'b001110;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;

  localparam logic [AluOpW-1:0] AluAdd = 3'b000;
  localparam logic [AluOpW-1:0] AluSub = 3'b001;
  localparam logic [AluOpW-1:0] AluAnd = 3'b010;
  localparam logic [AluOpW-1:0] AluOr  = 3'b011;
  localparam logic [AluOpW-1:0] AluXor = 3'b100;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StError
  } state_e;

  // ClsIllegal is the all-zero encoding so a cleared class register is inert.
  typedef enum logic [2:0] {
    ClsIllegal,
    ClsRtype,
    ClsItype,
    ClsLw,
    ClsSw,
    ClsBeq
  } insn_class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle sequencer: instruction fields, ALU flag,
// shared memory port handshake and per-state datapath strobes.
interface multicycle_ctrl_if #(
  parameter int unsigned ALU_OP_W = 3
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                alu_zero;
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic                pc_branch;
  logic                ab_write;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_to_reg;
  logic                reg_write;
  logic                retire;
  logic                illegal_op;
  logic                bus_err;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_branch, ab_write, alu_src,
           alu_op, mem_to_reg, reg_write, retire, illegal_op, bus_err
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_branch, ab_write, alu_src,
           alu_op, mem_to_reg, reg_write, retire, illegal_op, bus_err
  );
endinterface

// File: rtl/insn_class_decode.sv
// Combinational opcode/funct decode into an instruction class and the ALU operation
// that class uses in EXEC.
module insn_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  output insn_class_e       cls_o,
  output logic [AluOpW-1:0] alu_op_o
);

  always_comb begin
    cls_o    = ClsIllegal;
    alu_op_o = AluAdd;
    case (opcode_i)
      OpR: begin
        cls_o = ClsRtype;
        // Unknown funct falls back to ADD.
        case (funct_i)
          FnSub:   alu_op_o = AluSub;
          FnAnd:   alu_op_o = AluAnd;
          FnOr:    alu_op_o = AluOr;
          FnXor:   alu_op_o = AluXor;
          default: alu_op_o = AluAdd;
        endcase
      end
      OpAddi: begin
        cls_o    = ClsItype;
        alu_op_o = AluAdd;
      end
      OpAndi: begin
        cls_o    = ClsItype;
        alu_op_o = AluAnd;
      end
      OpOri: begin
        cls_o    = ClsItype;
        alu_op_o = AluOr;
      end
      OpXori: begin
        cls_o    = ClsItype;
        alu_op_o = AluXor;
      end
      OpLw:    cls_o = ClsLw;
      OpSw:    cls_o = ClsSw;
      OpBeq: begin
        cls_o    = ClsBeq;
        alu_op_o = AluSub;
      end
      default: cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB) driving the shared
// memory port handshake and the datapath strobes, with a memory-wait timeout.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 3,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_e            state_q, state_d;
  insn_class_e       cls_q, cls_d;
  logic [AluOpW-1:0] alu_op_q, alu_op_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;

  insn_class_e       dec_cls;
  logic [AluOpW-1:0] dec_alu_op;
  logic [AluOpW-1:0] alu_op_out;
  logic              in_wait;
  logic              timeout;

  insn_class_decode u_decode (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu_op)
  );

  assign in_wait = ((state_q == StFetch) || (state_q == StMem)) && !bus.mem_ready;
  // The request stays up through the cycle the count reaches the limit; ERROR drops it.
  assign timeout = (WAIT_LIMIT != 0) && in_wait && (wait_cnt_q == CntW'(WAIT_LIMIT - 1));

  always_comb begin
    state_d        = state_q;
    cls_d          = cls_q;
    alu_op_d       = alu_op_q;
    wait_cnt_d     = '0;
    bus_err_d      = bus_err_q | timeout;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_branch  = 1'b0;
    bus.ab_write   = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.retire     = 1'b0;
    bus.illegal_op = 1'b0;
    alu_op_out     = AluAdd;

    if (in_wait && !timeout && (WAIT_LIMIT != 0)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      StFetch: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StDecode: begin
        bus.ab_write = 1'b1;
        cls_d        = dec_cls;
        alu_op_d     = dec_alu_op;
        if (dec_cls == ClsIllegal) begin
          bus.illegal_op = 1'b1;
          state_d        = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls_q)
          ClsRtype: begin
            alu_op_out = alu_op_q;
            state_d    = StWb;
          end
          ClsItype: begin
            bus.alu_src = 1'b1;
            alu_op_out  = alu_op_q;
            state_d     = StWb;
          end
          ClsLw, ClsSw: begin
            bus.alu_src = 1'b1;
            alu_op_out  = AluAdd;
            state_d     = StMem;
          end
          ClsBeq: begin
            alu_op_out    = AluSub;
            bus.pc_branch = bus.alu_zero;
            bus.retire    = 1'b1;
            state_d       = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        bus.iord      = 1'b1;
        bus.mem_read  = (cls_q == ClsLw);
        bus.mem_write = (cls_q == ClsSw);
        if (bus.mem_ready) begin
          if (cls_q == ClsSw) begin
            bus.retire = 1'b1;
            state_d    = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (cls_q == ClsLw);
        bus.retire     = 1'b1;
        state_d        = StFetch;
      end
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  assign bus.alu_op  = ALU_OP_W'(alu_op_out);
  assign bus.bus_err = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      cls_q      <= ClsIllegal;
      alu_op_q   <= AluAdd;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      alu_op_q   <= alu_op_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: a reactive memory driver, a
// per-instruction reference model and a monitor that checks each retire/illegal event.
module tb_multicycle_ctrl;

  localparam int unsigned WaitLimit = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALU_OP_W(3)) bus ();

  multicycle_ctrl #(
    .ALU_OP_W   (3),
    .WAIT_LIMIT (WaitLimit)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit ill;
    int lat;
    int aop;
    int asrc;
    bit br;
    int wb;
    bit m2r;
    bit st;
    bit ld;
  } exp_t;

  exp_t       exp_q[$];
  int         compared = 0;
  int         failed   = 0;
  bit         mon_en   = 1'b0;
  logic [5:0] legal_ops[8] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                               6'b001110, 6'b100011, 6'b101011, 6'b000100};
  logic [5:0] functs[5]    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one instruction given the wait cycles the memory will insert.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                 input int fw, input int mw);
    exp_t e;
    e = '{default: 0};
    case (op)
      6'b000000: begin
        e.lat = 4; e.wb = 1;
        case (fn)
          6'b100010: e.aop = 1;
          6'b100100: e.aop = 2;
          6'b100101: e.aop = 3;
          6'b100110: e.aop = 4;
          default:   e.aop = 0;
        endcase
      end
      6'b001000: begin e.lat = 4; e.wb = 1; e.asrc = 1; e.aop = 0; end
      6'b001100: begin e.lat = 4; e.wb = 1; e.asrc = 1; e.aop = 2; end
      6'b001101: begin e.lat = 4; e.wb = 1; e.asrc = 1; e.aop = 3; end
      6'b001110: begin e.lat = 4; e.wb = 1; e.asrc = 1; e.aop = 4; end
      6'b100011: begin e.lat = 5 + mw; e.wb = 1; e.asrc = 1; e.m2r = 1; e.ld = 1; end
      6'b101011: begin e.lat = 4 + mw; e.asrc = 1; e.st = 1; end
      6'b000100: begin e.lat = 3; e.aop = 1; e.br = z; end
      default:   begin e.lat = 2; e.ill = 1; end
    endcase
    e.lat += fw;
    return e;
  endfunction

  task automatic do_reset(input bit en_mon);
    mon_en        = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("rst_mem_read", int'(bus.mem_read), 1);
    chk("rst_strobes", int'({bus.mem_write, bus.iord, bus.ir_write, bus.pc_write, bus.pc_branch,
                             bus.ab_write, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                             bus.retire, bus.illegal_op}), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0);
    chk("rst_bus_err", int'(bus.bus_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = en_mon;
  endtask

  // Reactive memory: each request is held off for its programmed wait count.
  task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input bit z,
                          input int fw, input int mw);
    int req_idx, age, w, guard;
    bit done;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.alu_zero = z;
    exp_q.push_back(model(op, fn, z, fw, mw));
    req_idx = 0; age = 0; done = 1'b0; guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
      if (bus.mem_read || bus.mem_write) begin
        w = (req_idx == 0) ? fw : mw;
        if (age >= w) begin
          bus.mem_ready = 1'b1;
          req_idx++;
          age = 0;
        end else begin
          bus.mem_ready = 1'b0;
          age++;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.retire || bus.illegal_op) done = 1'b1;
    end
    chk("insn_done", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int cyc, wb_cnt, irw_cnt, e_aop, e_asrc;
    bit prev_ab, br, m2r, st, ld;
    exp_t e;
    cyc = 0; wb_cnt = 0; irw_cnt = 0; e_aop = -1; e_asrc = -1;
    prev_ab = 0; br = 0; m2r = 0; st = 0; ld = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        cyc = 0; wb_cnt = 0; irw_cnt = 0; e_aop = -1; e_asrc = -1;
        prev_ab = 0; br = 0; m2r = 0; st = 0; ld = 0;
        continue;
      end
      cyc++;
      if (bus.mem_read || bus.mem_write) chk("rw_exclusive", int'(bus.mem_read & bus.mem_write), 0);
      if (bus.ir_write) chk("fetch_iord", int'(bus.iord), 0);
      if (prev_ab) begin
        e_aop  = int'(bus.alu_op);
        e_asrc = int'(bus.alu_src);
      end
      prev_ab = bus.ab_write;
      if (bus.pc_branch) br = 1'b1;
      if (bus.reg_write) begin
        wb_cnt++;
        m2r = bus.mem_to_reg;
      end
      if (bus.mem_write) st = 1'b1;
      if (bus.mem_read && bus.iord) ld = 1'b1;
      if (bus.ir_write) irw_cnt++;
      if (bus.retire || bus.illegal_op) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("illegal_op", int'(bus.illegal_op), int'(e.ill));
          chk("retire", int'(bus.retire), int'(!e.ill));
          chk("latency", cyc, e.lat);
          chk("ir_write_count", irw_cnt, 1);
          chk("reg_write_count", wb_cnt, e.wb);
          chk("mem_write_seen", int'(st), int'(e.st));
          if (!e.ill) begin
            chk("exec_alu_op", e_aop, e.aop);
            chk("exec_alu_src", e_asrc, e.asrc);
            chk("pc_branch", int'(br), int'(e.br));
            chk("load_seen", int'(ld), int'(e.ld));
            if (e.wb != 0) chk("mem_to_reg", int'(m2r), int'(e.m2r));
          end
        end
        cyc = 0; wb_cnt = 0; irw_cnt = 0; e_aop = -1; e_asrc = -1;
        prev_ab = 0; br = 0; m2r = 0; st = 0; ld = 0;
      end
    end
  end

  initial begin : stim
    int n;
    int any;
    logic [5:0] op, fn;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;

    do_reset(1'b1);
    run_insn(6'b000000, 6'b100000, 1'b0, 0, 0);  // R-type ADD, zero wait
    run_insn(6'b100011, 6'b000000, 1'b0, 3, 3);  // LW, 3+3 waits -> 11 cycles
    run_insn(6'b000100, 6'b000000, 1'b1, 0, 0);  // BEQ taken
    run_insn(6'b000100, 6'b000000, 1'b0, 0, 0);  // BEQ not taken
    run_insn(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal
    run_insn(6'b101011, 6'b000000, 1'b0, 1, 2);  // SW
    run_insn(6'b000000, 6'b111111, 1'b0, 0, 0);  // unknown funct -> ADD
    run_insn(6'b001110, 6'b000000, 1'b0, 2, 0);  // XORI
    for (int i = 0; i < 200; i++) begin
      n  = $urandom_range(0, 8);
      op = (n == 8) ? 6'($urandom_range(0, 63)) : legal_ops[n];
      n  = $urandom_range(0, 5);
      fn = (n == 5) ? 6'($urandom_range(0, 63)) : functs[n];
      run_insn(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // Fetch never acknowledged: request held WaitLimit cycles, then ERROR.
    do_reset(1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.mem_read) n++;
    end
    chk("fetch_timeout_req_cycles", n, WaitLimit);
    chk("fetch_timeout_bus_err", int'(bus.bus_err), 1);

    // Store never acknowledged in MEM.
    do_reset(1'b0);
    bus.opcode = 6'b101011;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (bus.mem_write) n++;
    end
    chk("sw_timeout_write_cycles", n, WaitLimit);
    chk("sw_timeout_bus_err", int'(bus.bus_err), 1);
    chk("sw_timeout_mem_write", int'(bus.mem_write), 0);
    any = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      any |= int'({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write,
                   bus.retire, bus.illegal_op, bus.ab_write});
    end
    chk("error_quiet", any, 0);
    chk("error_bus_err_sticky", int'(bus.bus_err), 1);
    rst_n = 1'b0;
    #1;
    chk("error_reset_bus_err", int'(bus.bus_err), 0);
    chk("error_reset_fetch", int'(bus.mem_read), 1);

    // Reset asserted in the middle of a store's MEM wait.
    do_reset(1'b0);
    bus.opcode = 6'b101011;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    n = 0;
    while (!bus.mem_write && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("midmem_write_reached", int'(bus.mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midmem_write_dropped", int'(bus.mem_write), 0);
    chk("midmem_fetch_iord", int'(bus.iord), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midmem_after_fetch", int'(bus.mem_read), 1);
    chk("midmem_no_writeback", int'({bus.reg_write, bus.retire, bus.mem_write}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 64-bit CPU datapath.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- The datapath shares one memory port for instruction fetch and load/store; this block drives that port's request/ready handshake.
- Emits per-state datapath strobes: PC/IR write enables, ALU select and op, memory read/write, register writeback.

Parameters:
- ALU_OP_W, 3: width of alu_op. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- WAIT_LIMIT, 255: maximum cycles to wait for mem_ready before a bus error. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; R-type only
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  PC <= PC+4
- pc_branch  out  1  PC <= branch target
- ab_write  out  1  latch rs1/rs2 operands
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  ALU_OP_W  ALU operation
- mem_to_reg  out  1  0 = ALU result to register file, 1 = memory data
- reg_write  out  1  register-file write enable
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- bus_err  out  1  sticky; set on memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERROR.
- Reset (async, rst_n = 0): state = FETCH, wait counter = 0, bus_err = 0, instruction class register cleared. All outputs are 0 except mem_read, which is combinationally 1 in FETCH.
- Outputs are decoded from the registered state plus a class register (RTYPE, ITYPE, LW, SW, BEQ, ILLEGAL) latched in DECODE. alu_op for R-type comes from funct; an unknown funct gives ADD.
- FETCH:
  - mem_read = 1, iord = 0; hold until mem_ready.
  - In the mem_ready cycle: ir_write = 1, pc_write = 1, go to DECODE.
- DECODE:
  - ab_write = 1; latch class from opcode.
  - ILLEGAL opcode: illegal_op pulses and state returns to FETCH with no writeback. Otherwise go to EXEC.
- EXEC:
  - RTYPE: alu_src = 0, alu_op from funct, go to WB.
  - ITYPE (ADDI/ANDI/ORI/XORI): alu_src = 1, alu_op = ADD/AND/OR/XOR, go to WB.
  - LW or SW: alu_src = 1, alu_op = ADD, go to MEM.
  - BEQ: alu_src = 0, alu_op = SUB, pc_branch = alu_zero, retire = 1, go to FETCH.
- MEM:
  - iord = 1; mem_read (LW) or mem_write (SW) held steady until mem_ready.
  - On ready: SW gives retire = 1 and goes to FETCH; LW goes to WB.
- WB:
  - reg_write = 1; mem_to_reg = 1 only for LW; retire = 1; go to FETCH.
- Handshake:
  - A request stays asserted, with address source stable, until the mem_ready cycle.
  - mem_ready outside FETCH/MEM is ignored.
  - mem_read and mem_write are never both 1.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle without mem_ready and clears on state exit.
  - When it reaches WAIT_LIMIT (WAIT_LIMIT ≠ 0): drop the request, set bus_err, enter ERROR.
- ERROR: all strobes 0; leaves only via reset.
- Latency with zero-wait memory, FETCH to retire inclusive: BEQ 3, R/I-type 4, SW 4, LW 5. Each wait cycle adds 1.
- Reset mid-request drops the request immediately (asynchronous); no partial writeback occurs.

Decomposition:
- Shared package cpu_ctrl_pkg: opcode and funct localparams (ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, R 000000), ALU op codes, the state enum and the class enum.
- One natural sub-module, insn_class_decode: combinational opcode/funct to class + alu_op.

Test Plan:
- Reset, then R-type ADD (opcode 000000, funct 100000) with mem_ready always 1. Required: FETCH→DECODE→EXEC→WB; reg_write = 1 in cycle 4 with alu_op = 000 and mem_to_reg = 0; retire in cycle 4.
- LW with 3 wait cycles in both FETCH and MEM. Required: mem_read held with iord = 0, then with iord = 1; mem_to_reg = 1 and reg_write in WB; retire 11 cycles after FETCH entry.
- BEQ with alu_zero = 1, then BEQ with alu_zero = 0. Required: pc_branch = 1 in EXEC for the first only; each retires in 3 cycles.
- Opcode 111111. Required: illegal_op pulses in DECODE, no reg_write or mem_write, FETCH follows.
- WAIT_LIMIT = 4 with SW and mem_ready never asserted in MEM. Required: mem_write high 4 cycles, then 0; bus_err = 1; state stays in ERROR until rst_n is low.
- rst_n asserted mid-MEM of SW. Required: mem_write drops the same cycle with no clock edge needed; FETCH after release.
